booth4_seq_mul_ctrl: RTL and testbench



---
 rtl/booth4_seq_mul_ctrl_if.sv | 30 +++
 rtl/booth4_seq_mul_ctrl.sv | 149 ++++++++++++++
 tb/tb_booth4_seq_mul_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/booth4_seq_mul_ctrl_if.sv
// Handshake and compressor bus for the Booth radix-4 sequential multiplier controller.
// Slave modport is the controller side; master is the operand source / product sink / compressor.
interface booth4_seq_mul_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int PP_PER_CYCLE = 4
);
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int CMP_IN = PP_PER_CYCLE + 2;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_a;
    logic [DATA_WIDTH-1:0]  in_b;
    logic [CMP_IN*PW-1:0]   cmp_in_op;
    logic [PW-1:0]          cmp_out_0;
    logic [PW-1:0]          cmp_out_1;
    logic                   out_valid;
    logic                   out_ready;
    logic [PW-1:0]          out_product;

    modport slave (
        input  in_valid, in_a, in_b, cmp_out_0, cmp_out_1, out_ready,
        output in_ready, cmp_in_op, out_valid, out_product
    );

    modport master (
        output in_valid, in_a, in_b, cmp_out_0, cmp_out_1, out_ready,
        input  in_ready, cmp_in_op, out_valid, out_product
    );
endinterface

// File: rtl/booth4_seq_mul_ctrl.sv
// Sequential Booth radix-4 multiplier controller feeding an external carry-save compressor.
// Optional early termination on all-zero/all-one upper multiplier bits: BOOTH4_SEQ_ZERO_SKIP_EN.
module booth4_seq_mul_lane #(
    parameter int DW = 32,
    parameter int PW = 64,
    parameter int SH = 0
) (
    input  logic [DW-1:0] i_a,
    input  logic [2:0]    i_trip,
    output logic [PW-1:0] o_pp
);
    logic [PW-1:0] w_ax;
    logic [PW-1:0] w_dig;

    assign w_ax = {{(PW-DW){i_a[DW-1]}}, i_a};

    always_comb begin
        w_dig = '0;
        case (i_trip)
            3'b001, 3'b010: w_dig = w_ax;
            3'b011:         w_dig = w_ax << 1;
            3'b100:         w_dig = -(w_ax << 1);
            3'b101, 3'b110: w_dig = -w_ax;
            default:        w_dig = '0;
        endcase
    end

    assign o_pp = w_dig << SH;
endmodule

module booth4_seq_mul_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int PP_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    booth4_seq_mul_ctrl_if.slave   bus
);
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int N_ITER = DATA_WIDTH / (2 * PP_PER_CYCLE);
    localparam int CMP_IN = PP_PER_CYCLE + 2;
    localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int SW     = $clog2(PW) + 1;
    localparam int GW     = 2 * PP_PER_CYCLE + 1;

    typedef enum logic [1:0] {IDLE, COMPRESS, ADD, DONE} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [PW-1:0]         r_acc0;
    logic [PW-1:0]         r_acc1;
    logic [CW-1:0]         r_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [PW-1:0]         r_out_product;

    logic [SW-1:0]                          w_grp_sh;
    logic [GW-1:0]                          w_bgrp;
    logic [PP_PER_CYCLE-1:0][PW-1:0]        w_pp;
    logic [CMP_IN*PW-1:0]                   w_cmp;
    logic                                   w_last;
    logic                                   w_skip;

    assign w_grp_sh = SW'(32'(r_cnt) * 2 * PP_PER_CYCLE);
    // Multiplier with the implicit b[-1]=0 appended, aligned so the group's first triplet sits at bit 0
    assign w_bgrp   = GW'({r_b, 1'b0} >> w_grp_sh);
    assign w_last   = (r_cnt == CW'(N_ITER - 1));

    genvar m;
    generate
        for (m = 0; m < PP_PER_CYCLE; m++) begin : g_lane
            booth4_seq_mul_lane #(.DW(DATA_WIDTH), .PW(PW), .SH(2*m)) u_lane (
                .i_a    (r_a),
                .i_trip (w_bgrp[2*m +: 3]),
                .o_pp   (w_pp[m])
            );
        end
    endgenerate

`ifdef BOOTH4_SEQ_ZERO_SKIP_EN
    logic [SW-1:0]                w_rem_sh;
    logic signed [DATA_WIDTH-1:0] w_rem;
    // Arithmetic shift keeps the sign, so remaining bits are uniform iff the result is 0 or -1
    assign w_rem_sh = SW'((32'(r_cnt) + 1) * 2 * PP_PER_CYCLE - 1);
    assign w_rem    = $signed(r_b) >>> w_rem_sh;
    assign w_skip   = !w_last && ((w_rem == '0) || (&w_rem));
`else
    assign w_skip   = 1'b0;
`endif

    always_comb begin
        w_cmp = '0;
        if (r_state == COMPRESS) begin
            for (int k = 0; k < PP_PER_CYCLE; k++)
                w_cmp[k*PW +: PW] = w_pp[k] << w_grp_sh;
            w_cmp[PP_PER_CYCLE*PW +: PW]     = r_acc0;
            w_cmp[(PP_PER_CYCLE+1)*PW +: PW] = r_acc1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_acc0        <= '0;
            r_acc1        <= '0;
            r_cnt         <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a        <= bus.in_a;
                    r_b        <= bus.in_b;
                    r_acc0     <= '0;
                    r_acc1     <= '0;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b0;
                    r_state    <= COMPRESS;
                end
                COMPRESS: begin
                    r_acc0 <= bus.cmp_out_0;
                    r_acc1 <= bus.cmp_out_1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last || w_skip) r_state <= ADD;
                end
                ADD: begin
                    r_out_product <= r_acc0 + r_acc1;
                    r_out_valid   <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_product = r_out_product;
    assign bus.cmp_in_op   = w_cmp;
endmodule

// File: tb/tb_booth4_seq_mul_ctrl.sv
// Directed + random bench for booth4_seq_mul_ctrl with a carry-save 3:2 chain as the compressor.
module tb_booth4_seq_mul_ctrl;
    localparam int DW     = 32;
    localparam int PP     = 4;
    localparam int PW     = 2 * DW;
    localparam int CMP_IN = PP + 2;
    localparam int N_ITER = DW / (2 * PP);

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    booth4_seq_mul_ctrl_if #(.DATA_WIDTH(DW), .PP_PER_CYCLE(PP)) bus ();

    booth4_seq_mul_ctrl #(.DATA_WIDTH(DW), .PP_PER_CYCLE(PP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compressor: chain of 3:2 carry-save adders reducing all slots to two operands
    always_comb begin
        logic [PW-1:0] s, c, x, t;
        s = bus.cmp_in_op[0 +: PW];
        c = bus.cmp_in_op[PW +: PW];
        for (int k = 2; k < CMP_IN; k++) begin
            x = bus.cmp_in_op[k*PW +: PW];
            t = s ^ c ^ x;
            c = ((s & c) | (s & x) | (c & x)) << 1;
            s = t;
        end
        bus.cmp_out_0 = s;
        bus.cmp_out_1 = c;
    end

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [PW-1:0] sa, sb;
        sa = {{DW{a[DW-1]}}, a};
        sb = {{DW{b[DW-1]}}, b};
        return PW'(sa * sb);
    endfunction

    // Cycles from accept edge until out_valid is seen
    function automatic int ref_lat(input logic [DW-1:0] b);
        int lat;
        lat = N_ITER + 1;
`ifdef BOOTH4_SEQ_ZERO_SKIP_EN
        for (int g = N_ITER - 2; g >= 0; g--) begin
            logic uni;
            uni = 1'b1;
            for (int i = 2*PP*(g+1) - 1; i < DW; i++)
                if (b[i] != b[DW-1]) uni = 1'b0;
            if (uni) lat = g + 2;
        end
`endif
        return lat;
    endfunction

    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("in_ready_wait", PW'(bus.in_ready), PW'(1));
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input logic [PW-1:0] exp, input int lat);
        int  n;
        logic rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_busy_ready"}, PW'(rdy_seen), PW'(0));
        chk({tag, "_lat"}, PW'(n), PW'(lat));
        chk({tag, "_prod"}, bus.out_product, exp);
    endtask

    task automatic release_op(input string tag);
        @(posedge clk); #1;
        chk({tag, "_vld_clr"}, PW'(bus.out_valid), PW'(0));
        chk({tag, "_rdy_set"}, PW'(bus.in_ready), PW'(1));
    endtask

    task automatic do_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [PW-1:0] exp);
        start_op(a, b);
        wait_res(tag, exp, ref_lat(b));
        release_op(tag);
    endtask

    initial begin
        logic [PW-1:0] held;
        logic [DW-1:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #12;
        chk("rst_in_ready", PW'(bus.in_ready), PW'(1));
        chk("rst_out_valid", PW'(bus.out_valid), PW'(0));
        chk("rst_product", bus.out_product, '0);
        chk("rst_cmp_in", bus.cmp_in_op[PW-1:0], '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("a15_b3",   32'd15,        32'd3,         64'd45);
        do_op("am7_b6",   -32'sd7,       32'd6,         64'hFFFF_FFFF_FFFF_FFD6);
        do_op("am1_bm1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        do_op("min_min",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        do_op("min_max",  32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        do_op("a9_b3",    32'd9,         32'd3,         64'd27);
        do_op("a9_bm2",   32'd9,         -32'sd2,       64'hFFFF_FFFF_FFFF_FFEE);
        do_op("a9_b4e7",  32'd9,         32'h4000_0000, 64'h0000_0002_4000_0000);

        // Backpressure: product held, in_valid ignored while DONE
        bus.out_ready = 1'b0;
        start_op(32'd1000, -32'sd3);
        wait_res("bp", 64'hFFFF_FFFF_FFFF_F448, ref_lat(-32'sd3));
        held = bus.out_product;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'd77;
            bus.in_b     = 32'd11;
            @(posedge clk); #1;
            chk("bp_hold_vld", PW'(bus.out_valid), PW'(1));
            chk("bp_hold_prod", bus.out_product, 64'hFFFF_FFFF_FFFF_F448);
            chk("bp_hold_rdy", PW'(bus.in_ready), PW'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        release_op("bp");
        chk("bp_prod_kept", bus.out_product, held);
        do_op("after_bp", 32'd77, 32'd11, 64'd847);

        // Asynchronous reset in the second COMPRESS cycle
        start_op(32'd123, 32'd456);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", PW'(bus.in_ready), PW'(1));
        chk("mid_rst_out_valid", PW'(bus.out_valid), PW'(0));
        chk("mid_rst_product", bus.out_product, '0);
        chk("mid_rst_cmp_acc0", bus.cmp_in_op[PP*PW +: PW], '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("a5_bm5", 32'd5, -32'sd5, 64'hFFFF_FFFF_FFFF_FFE7);

        for (int i = 0; i < 1500; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = $urandom_range(255, 0);
            if (i % 5 == 2) rb = -$urandom_range(300, 1);
            do_op("rand", ra, rb, ref_mul(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
